// File: rtl/shift_sequencer_if.sv
// Bundle of the sequencer's command, result and shifter-side signals.
// The slave modport is the sequencer; the master side issues programs and supplies the shifter.
interface shift_sequencer_if #(
    parameter int SIZE  = 5,
    parameter int STEPS = 8
);
    localparam int CW = $clog2(STEPS + 1);

    logic               start;
    logic [SIZE-1:0]    din;
    logic [2*STEPS-1:0] ops;
    logic [CW-1:0]      count;
    logic [SIZE-1:0]    shf_data;
    logic [1:0]         shf_coef;
    logic [SIZE-1:0]    shf_result;
    logic               busy;
    logic               done;
    logic [SIZE-1:0]    dout;
    logic               ovf;

    modport slave (
        input  start, din, ops, count, shf_result,
        output shf_data, shf_coef, busy, done, dout, ovf
    );

    modport master (
        output start, din, ops, count, shf_result,
        input  shf_data, shf_coef, busy, done, dout, ovf
    );
endinterface

// File: rtl/shift_sequencer.sv
// Runs a short program of shift codes through an external combinational shifter.
// Define SHIFT_OVF_EN to enable the sticky left-shift overflow flag; otherwise ovf is tied low.
module shift_sequencer #(
    parameter int SIZE  = 5,
    parameter int STEPS = 8
) (
    input  logic              clk,
    input  logic              rst,
    shift_sequencer_if.slave  bus
);
    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SIZE-1:0]    acc_q, acc_d;
    logic [2*STEPS-1:0] opreg_q, opreg_d;
    logic [CW-1:0]      rem_q, rem_d;
    logic [SIZE-1:0]    dout_q, dout_d;
    logic [CW-1:0]      count_clamped;
    logic [1:0]         code;
    logic               accept;

    assign count_clamped = (bus.count > CW'(STEPS)) ? CW'(STEPS) : bus.count;
    assign code          = opreg_q[1:0];
    assign accept        = (state_q == S_IDLE) && bus.start;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        opreg_d = opreg_q;
        rem_d   = rem_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.din;
                    opreg_d = bus.ops;
                    rem_d   = count_clamped;
                    state_d = (count_clamped != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (code != 2'b11) acc_d = bus.shf_result;
                opreg_d = opreg_q >> 2;
                rem_d   = rem_q - CW'(1);
                if (rem_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                dout_d  = acc_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            opreg_q <= '0;
            rem_q   <= '0;
            dout_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q <= state_d;
            acc_q   <= acc_d;
            opreg_q <= opreg_d;
            rem_q   <= rem_d;
            dout_q  <= dout_d;
        end
    end

    // The shifter only sees a live code while stepping; otherwise it is parked on no-op.
    assign bus.shf_data = acc_q;
    assign bus.shf_coef = (state_q == S_SHIFT) ? code : 2'b11;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.dout     = dout_q;

`ifdef SHIFT_OVF_EN
    logic ovf_q;
    logic ovf_hit;

    // A left shift overflows when any bit it pushes out of the word is set.
    assign ovf_hit = (state_q == S_SHIFT) &&
                     (((code == 2'b00) && acc_q[SIZE-1]) ||
                      ((code == 2'b01) && (acc_q[SIZE-1:SIZE-2] != 2'b00)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (ovf_hit) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: program vector table plus hand-written multi-cycle sequences.
// The bench also plays the role of the external combinational shifter.
module tb_shift_sequencer;
    localparam int SIZE  = 5;
    localparam int STEPS = 8;
    localparam int CW    = $clog2(STEPS + 1);
`ifdef SHIFT_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    shift_sequencer_if #(.SIZE(SIZE), .STEPS(STEPS)) sq_if ();

    shift_sequencer #(.SIZE(SIZE), .STEPS(STEPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sq_if.slave)
    );

    always #5 clk = ~clk;

    // Reference shifter: 00 left 1, 01 left 2, 10 logical right 1, 11 pass-through.
    always_comb begin
        case (sq_if.shf_coef)
            2'b00:   sq_if.shf_result = sq_if.shf_data << 1;
            2'b01:   sq_if.shf_result = sq_if.shf_data << 2;
            2'b10:   sq_if.shf_result = sq_if.shf_data >> 1;
            default: sq_if.shf_result = sq_if.shf_data;
        endcase
    end

    typedef struct {
        string              name;
        logic [SIZE-1:0]    din;
        logic [2*STEPS-1:0] ops;
        logic [CW-1:0]      count;
        logic [SIZE-1:0]    exp_dout;
        logic               exp_ovf;
        int                 exp_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [SIZE-1:0] din, input logic [2*STEPS-1:0] ops,
                         input logic [CW-1:0] count);
        sq_if.start = 1'b1;
        sq_if.din   = din;
        sq_if.ops   = ops;
        sq_if.count = count;
    endtask

    // Starts a program from IDLE, measures done latency and checks the settled result.
    task automatic run_prog(input vec_t v);
        int lat;
        @(negedge clk);
        issue(v.din, v.ops, v.count);
        @(negedge clk);
        sq_if.start = 1'b0;
        lat = 1;
        while (sq_if.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({v.name, " latency"}, lat, v.exp_lat);
        @(negedge clk);
        check({v.name, " done one cycle"}, sq_if.done, 1'b0);
        check({v.name, " busy after"}, sq_if.busy, 1'b0);
        check({v.name, " dout"}, sq_if.dout, v.exp_dout);
        check({v.name, " ovf"}, sq_if.ovf, v.exp_ovf);
    endtask

    initial begin
        int seen_done;

        vecs[0] = '{"left1_left2",   5'b00011, 16'h0004, 4'd2,  5'b11000, 1'b0,   3};
        vecs[1] = '{"left2_ovf",     5'b01100, 16'h0001, 4'd1,  5'b10000, OVF_ON, 2};
        vecs[2] = '{"right1",        5'b10110, 16'h0002, 4'd1,  5'b01011, 1'b0,   2};
        vecs[3] = '{"count0",        5'b10101, 16'hFFFF, 4'd0,  5'b10101, 1'b0,   1};
        vecs[4] = '{"noop_right",    5'b00111, 16'h000B, 4'd2,  5'b00011, 1'b0,   3};
        vecs[5] = '{"clamp15",       5'b11111, 16'hAAAA, 4'd15, 5'b00000, 1'b0,   9};
        vecs[6] = '{"left1_x4",      5'b00001, 16'h0000, 4'd4,  5'b10000, 1'b0,   5};
        vecs[7] = '{"left1_x8_ovf",  5'b00001, 16'h0000, 4'd8,  5'b00000, OVF_ON, 9};
        vecs[8] = '{"partial_prog",  5'b00011, 16'h0006, 4'd1,  5'b00001, 1'b0,   2};

        rst         = 1'b0;
        sq_if.start = 1'b0;
        sq_if.din   = '0;
        sq_if.ops   = '0;
        sq_if.count = '0;
        #1;
        check("reset busy", sq_if.busy, 1'b0);
        check("reset done", sq_if.done, 1'b0);
        check("reset dout", sq_if.dout, 5'b00000);
        check("reset ovf", sq_if.ovf, 1'b0);
        check("reset shf_data", sq_if.shf_data, 5'b00000);
        check("reset shf_coef", sq_if.shf_coef, 2'b11);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Cycle-by-cycle view of a two-step program through the shifter port.
        @(negedge clk);
        issue(5'b00011, 16'h0004, 4'd2);
        @(negedge clk);
        sq_if.start = 1'b0;
        check("seq step0 shf_data", sq_if.shf_data, 5'b00011);
        check("seq step0 shf_coef", sq_if.shf_coef, 2'b00);
        check("seq step0 busy", sq_if.busy, 1'b1);
        @(negedge clk);
        check("seq step1 shf_data", sq_if.shf_data, 5'b00110);
        check("seq step1 shf_coef", sq_if.shf_coef, 2'b01);
        @(negedge clk);
        check("seq done", sq_if.done, 1'b1);
        check("seq done busy", sq_if.busy, 1'b1);
        check("seq done shf_data", sq_if.shf_data, 5'b11000);
        check("seq done shf_coef", sq_if.shf_coef, 2'b11);
        @(negedge clk);
        check("seq idle dout", sq_if.dout, 5'b11000);
        check("seq idle shf_coef", sq_if.shf_coef, 2'b11);

        for (int i = 0; i < 9; i++) run_prog(vecs[i]);

        // Start pulses while busy (in SHIFT and in DONE) must be ignored.
        @(negedge clk);
        issue(5'b00111, 16'h000B, 4'd2);
        @(negedge clk);
        issue(5'b11111, 16'h0000, 4'd1);
        @(negedge clk);
        sq_if.start = 1'b0;
        @(negedge clk);
        check("busy_start done", sq_if.done, 1'b1);
        issue(5'b11111, 16'h0000, 4'd1);
        @(negedge clk);
        sq_if.start = 1'b0;
        check("busy_start dout", sq_if.dout, 5'b00011);
        check("busy_start idle", sq_if.busy, 1'b0);
        @(negedge clk);
        check("busy_start not rerun", sq_if.busy, 1'b0);

        // Reset in the middle of a four-step run aborts it without a done pulse.
        @(negedge clk);
        issue(5'b01100, 16'h0001, 4'd1);
        @(negedge clk);
        sq_if.start = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        issue(5'b00001, 16'h0000, 4'd4);
        @(negedge clk);
        sq_if.start = 1'b0;
        @(negedge clk);
        check("abort pre busy", sq_if.busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("abort busy", sq_if.busy, 1'b0);
        check("abort done", sq_if.done, 1'b0);
        check("abort dout", sq_if.dout, 5'b00000);
        check("abort ovf", sq_if.ovf, 1'b0);
        check("abort shf_data", sq_if.shf_data, 5'b00000);
        check("abort shf_coef", sq_if.shf_coef, 2'b11);
        seen_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (sq_if.done === 1'b1) seen_done++;
        end
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (sq_if.done === 1'b1 || sq_if.busy === 1'b1) seen_done++;
        end
        check("abort no done", seen_done, 0);

        run_prog(vecs[0]);
        run_prog(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running, want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter SIZE, default 5, SHALL set the data word width, matching the shifter datapath width.
REQ-002 Parameter STEPS, default 8, SHALL set the maximum number of shift operations in one program.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request a new program run when high.
REQ-006 din  input  SIZE  SHALL carry the operand, captured at start.
REQ-007 ops  input  2*STEPS  SHALL carry the program; step k uses ops[2k+1:2k].
REQ-008 count  input  $clog2(STEPS+1)  SHALL give the number of steps to run (0..STEPS).
REQ-009 shf_data  output  SIZE  SHALL drive the shifter data input.
REQ-010 shf_coef  output  2  SHALL drive the shifter coefficient input.
REQ-011 shf_result  input  SIZE  SHALL return the shifter's combinational result.
REQ-012 busy  output  1  SHALL be high in LOAD-free states SHIFT and DONE.
REQ-013 done  output  1  SHALL pulse high for exactly one cycle at program end.
REQ-014 dout  output  SIZE  SHALL present the final result, held until the next accepted start.
REQ-015 ovf  output  1  SHALL be the sticky overflow flag (see Configuration).

Function
REQ-016 Coefficient codes SHALL be: 00 = left by 1, 01 = left by 2, 10 = right by 1 (logical), 11 = no-op.
REQ-017 FSM SHALL have states IDLE, SHIFT, DONE.
REQ-018 In IDLE with start=1, the block SHALL load acc<=din, opreg<=ops, rem<=count, ovf<=0, and go to SHIFT if count!=0, else to DONE.
REQ-019 start SHALL be ignored in SHIFT and DONE.
REQ-020 In SHIFT, shf_data SHALL equal acc and shf_coef SHALL equal opreg[1:0] in the same cycle.
REQ-021 At each SHIFT edge, acc SHALL take shf_result for codes 00/01/10, hold for code 11; opreg SHALL shift right by 2; rem SHALL decrement.
REQ-022 When rem==1 at a SHIFT edge, the next state SHALL be DONE.
REQ-023 In DONE, done SHALL be 1 and dout SHALL load acc; the next state SHALL be IDLE unconditionally.
REQ-024 Latency: done SHALL assert count+1 cycles after the edge that accepted start (1 cycle for count=0).
REQ-025 count>STEPS SHALL be clamped to STEPS.
REQ-026 In IDLE and DONE, shf_data SHALL be acc and shf_coef SHALL be 11.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, acc=0, opreg=0, rem=0, dout=0, done=0, busy=0, ovf=0, shf_data=0, shf_coef=11, including mid-program; the aborted run SHALL produce no done.

Configuration
REQ-028 With macro SHIFT_OVF_EN defined, ovf SHALL set when a code-00 step has acc[SIZE-1]=1 or a code-01 step has acc[SIZE-1:SIZE-2]!=0, and stay set until the next accepted start or reset.
REQ-029 Without SHIFT_OVF_EN, the ovf port SHALL exist and be constant 0.

Verification (SIZE=5, STEPS=8)
REQ-030 din=00011, ops[3:0]=01_00, count=2 -> acc 00110 then 11000; done 3 cycles after start; dout=11000; ovf=0.
REQ-031 din=10110, ops[1:0]=10, count=1 -> dout=01011, done 2 cycles after start.
REQ-032 din=10101, count=0 -> done 1 cycle after start, dout=10101, shf_coef stays 11.
REQ-033 din=01100, ops[1:0]=01, count=1 -> dout=10000; ovf=1 with SHIFT_OVF_EN, 0 without.
REQ-034 din=00111, ops[3:0]=10_11, count=2 -> step 0 holds 00111, step 1 gives 00011; start pulses while busy are ignored.
REQ-035 rst low during SHIFT of a count=4 run -> all outputs at reset values next sample, no done; new start after release runs normally.
